// File: rtl/sd_serializer.sv
// Parallel-to-serial front end for the serial sequence detector.
// Streams WIDTH-bit words one bit per clock, with a one-word holding buffer so words run gap-free.
module sd_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shift_q, shift_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic xfer;
   logic last;
   logic head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         shift_q      <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   // in_ready depends on registered state only, never on in_valid.
   assign in_ready = !hold_valid_q;
   assign xfer     = in_valid && in_ready;
   assign last     = (state_q == StShift) && (cnt_q == CntW'(WIDTH - 1));
   assign head     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      cnt_d        = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (xfer) begin
               shift_d = in_data;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (!last) begin
               shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
               cnt_d   = cnt_q + CntW'(1);
               if (xfer) begin
                  hold_d       = in_data;
                  hold_valid_d = 1'b1;
               end
            end else if (hold_valid_q) begin
               // Held word moves first; in_ready rises the following cycle.
               shift_d      = hold_q;
               hold_valid_d = 1'b0;
               cnt_d        = '0;
            end else if (xfer) begin
               shift_d = in_data;
               cnt_d   = '0;
            end else begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_valid = (state_q == StShift);
      out_last  = last;
      out_bit   = out_valid ? head : IDLE_BIT;
      busy      = out_valid || hold_valid_q;
   end

endmodule

// File: tb/tb_sd_serializer.sv
// Self-checking bench for sd_serializer: two instances (MSB-first/idle 0, LSB-first/idle 1)
// share stimulus and are compared against a word-queue model of the output stream.
module tb_sd_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_data;
   logic         in_valid;

   logic a_ready, a_bit, a_valid, a_last, a_busy;
   logic b_ready, b_bit, b_valid, b_last, b_busy;

   sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_msb (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (a_ready),
      .out_bit   (a_bit),
      .out_valid (a_valid),
      .out_last  (a_last),
      .busy      (a_busy)
   );

   sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (b_ready),
      .out_bit   (b_bit),
      .out_valid (b_valid),
      .out_last  (b_last),
      .busy      (b_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Words accepted but not fully emitted; head word is on the line, idx is its current bit.
   logic [W-1:0] words[$];
   int           idx = 0;

   logic [W-1:0] cap;
   int           cap_n;
   bit           capture = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_bit(input bit msb_first, input logic idle);
      logic [W-1:0] w;
      if (words.size() == 0) return idle;
      w = words[0];
      return msb_first ? w[W-1-idx] : w[idx];
   endfunction

   task automatic check_outputs();
      logic ev, el, er;
      ev = words.size() > 0;
      el = ev && (idx == W - 1);
      er = words.size() < 2;
      check_eq("msb out_valid", a_valid, ev);
      check_eq("msb out_last",  a_last,  el);
      check_eq("msb out_bit",   a_bit,   model_bit(1'b1, 1'b0));
      check_eq("msb busy",      a_busy,  ev);
      check_eq("msb in_ready",  a_ready, er);
      check_eq("lsb out_valid", b_valid, ev);
      check_eq("lsb out_last",  b_last,  el);
      check_eq("lsb out_bit",   b_bit,   model_bit(1'b0, 1'b1));
      check_eq("lsb busy",      b_busy,  ev);
      check_eq("lsb in_ready",  b_ready, er);
      if (capture && a_valid) begin
         cap = {cap[W-2:0], a_bit};
         cap_n++;
      end
   endtask

   function automatic void model_edge(input logic v, input logic [W-1:0] d);
      bit xfer;
      xfer = v && (words.size() < 2);
      if (words.size() > 0) begin
         idx++;
         if (idx == W) begin
            void'(words.pop_front());
            idx = 0;
         end
      end
      if (xfer) words.push_back(d);
   endfunction

   // Called at a falling edge: check, drive, advance one clock, return at the next falling edge.
   task automatic cycle(input logic v, input logic [W-1:0] d);
      check_outputs();
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      @(negedge clk);
      check_outputs();
      @(negedge clk);
      reset = 1'b0;

      // Single word 8'h90, captured bit-serially from the MSB-first instance.
      capture = 1'b1;
      cap     = '0;
      cap_n   = 0;
      cycle(1'b1, 8'h90);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);
      capture = 1'b0;
      check_eq("single word bits",  cap,   32'h90);
      check_eq("single word count", cap_n, 8);

      // Back-to-back A5, 3C, then FF waiting behind a full holding register.
      capture = 1'b1;
      cap_n   = 0;
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h3C);
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'hFF);
      for (int i = 0; i < 22; i++) cycle(1'b0, 8'h00);
      capture = 1'b0;
      check_eq("back-to-back bit count", cap_n, 24);

      // Just-in-time: next word offered only on the last-bit cycle.
      cycle(1'b1, 8'h5A);
      for (int i = 0; i < 7; i++) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h81);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);

      // Bit order on the LSB-first instance: 8'h01 -> 1 then seven 0s.
      cycle(1'b1, 8'h01);
      for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00);

      // Asynchronous reset at bit 3 of F0 with a word held.
      cycle(1'b1, 8'hF0);
      cycle(1'b1, 8'h77);
      cycle(1'b0, 8'h00);
      cycle(1'b0, 8'h00);
      check_outputs();
      reset = 1'b1;
      #1;
      words.delete();
      idx = 0;
      check_eq("reset out_valid", a_valid, 1'b0);
      check_eq("reset busy",      a_busy,  1'b0);
      check_eq("reset in_ready",  a_ready, 1'b1);
      check_eq("reset out_bit",   a_bit,   1'b0);
      check_eq("reset lsb out_bit", b_bit, 1'b1);
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'hC3);
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00);

      // Idle with changing in_data but no in_valid.
      for (int i = 0; i < 20; i++) cycle(1'b0, W'($urandom));

      // Randomized traffic.
      for (int i = 0; i < 600; i++) cycle(($urandom_range(0, 9) < 6), W'($urandom));
      for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);
      check_outputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_serializer.md
Name: sd_serializer

Overview:
- Parallel-to-serial front end for the serial sequence-detector stage.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line.
- Output is driven at a defined idle level when no word is in flight, because the detector samples its input every clock and has no valid qualifier.
- One-word holding buffer lets back-to-back words stream with no idle bit between them.

Parameters:
- WIDTH, 8, bits per input word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on out_bit while out_valid is 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out_bit  output  1  serial bit, feeds detector input.
- out_valid  output  1  out_bit carries payload this cycle.
- out_last  output  1  current out_bit is the final bit of its word.
- busy  output  1  shifter or holding buffer occupied.

Behaviour:
- Reset values: state=IDLE, shifter, bit counter and holding register cleared, hold_valid=0. While reset is high and after it: out_valid=0, out_last=0, out_bit=IDLE_BIT, busy=0, in_ready=1.
- Reset mid-word: all in-flight and held words are discarded. No partial bits are emitted after reset deasserts.
- Handshake:
  - A transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_valid. This is combinational from registers only, with no path from in_valid.
  - in_data is sampled only on a transfer edge.
  - in_valid without in_ready: the word is held off by upstream. The block places no requirement on upstream to keep in_data stable.
- States:
  - IDLE: shifter empty.
    - Transfer → load the shifter, bit_cnt=0, go to SHIFT.
  - SHIFT: one bit per clock.
    - out_bit = current head bit (MSB or LSB per MSB_FIRST).
    - out_valid=1.
    - out_last = (bit_cnt==WIDTH-1).
    - Not last bit: shift, bit_cnt+1.
    - Last bit with hold_valid=1: load the shifter from the holding register, clear hold_valid, bit_cnt=0, stay in SHIFT. No gap.
    - Last bit with hold_valid=0 and a transfer on the same edge: load in_data directly into the shifter, stay in SHIFT. No gap.
    - Last bit with no held word and no transfer: go to IDLE.
    - Not last bit with a transfer: word goes to the holding register, hold_valid=1.
- Outputs: out_bit, out_valid and out_last are combinational from registered state only.
  - In IDLE: out_valid=0, out_last=0, out_bit=IDLE_BIT.
- Latency: a word transferred at edge k presents its first bit in the cycle after edge k, when the shifter was idle. The word occupies exactly WIDTH consecutive out_valid cycles.
- Throughput: one bit per clock sustained. A word is accepted at most every WIDTH cycles once the holding register is full.
- busy = (state==SHIFT) || hold_valid.
- bit_cnt width: $clog2(WIDTH). It never exceeds WIDTH-1.
- Simultaneous holding-register unload and new transfer cannot occur, since in_ready=0 while hold_valid=1. The held word moves first, and in_ready rises the following cycle.

Test Plan:
1. Single word: WIDTH=8, MSB_FIRST=1, in_data=8'h90 transferred at edge 0 → out_bit=1,0,0,1,0,0,0,0 on cycles 1..8; out_valid high for exactly those 8 cycles; out_last only on cycle 8; IDLE (out_bit=0, busy=0) from cycle 9. With the detector attached, the detector output pulses on cycle 4.
2. Back-to-back: in_valid held high with words 8'hA5 then 8'h3C → 16 contiguous out_valid bits 10100101 00111100 with no gap. in_ready falls after the second transfer and rises the cycle after the last bit of 8'hA5. A third word 8'hFF waits until then.
3. Just-in-time: holding register empty, word 8'h81 presented only on the last-bit cycle of the preceding word → transferred directly into the shifter; no idle cycle between words.
4. Bit order: MSB_FIRST=0, in_data=8'h01 → out_bit=1 then seven 0s. With IDLE_BIT=1, out_bit=1 while idle.
5. Reset mid-operation: assert reset asynchronously at bit 3 of 8'hF0 with a word held → out_valid and busy drop immediately, in_ready=1; after deassertion no bits of either word appear, and the next transfer serializes normally.
6. Idle/backpressure: in_valid=0 for 20 cycles → out_valid=0, out_bit=IDLE_BIT throughout; a detector fed from this block reports no detection.
